// File: rtl/rvsteel_uart_bridge.sv
// UART-controlled bus initiator: decodes 8N1 command frames into single
// reads/writes on the IO bus and returns an ack, read data or an error byte.
module rvsteel_uart_bridge #(
   parameter int unsigned CLOCK_FREQUENCY = 50000000,
   parameter int unsigned UART_BAUD_RATE  = 9600,
   parameter int unsigned BUS_TIMEOUT     = 1024
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic [31:0] rw_address,
   input  logic [31:0] read_data,
   output logic        read_request,
   input  logic        read_response,
   output logic [31:0] write_data,
   output logic [3:0]  write_strobe,
   output logic        write_request,
   input  logic        write_response,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        bridge_busy
);

   localparam int unsigned CYCLES_PER_BAUD = CLOCK_FREQUENCY / UART_BAUD_RATE;
   localparam int unsigned BAUD_W          = $clog2(CYCLES_PER_BAUD + 1);
   localparam int unsigned TMO_W           = $clog2(BUS_TIMEOUT + 1);
   localparam logic [7:0]  CMD_WRITE       = 8'h57;
   localparam logic [7:0]  CMD_READ        = 8'h52;
   localparam logic [7:0]  RSP_ACK         = 8'h4B;
   localparam logic [7:0]  RSP_BAD         = 8'h3F;
   localparam logic [7:0]  RSP_ERR         = 8'h45;

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_REPLY} state_e;

   logic [1:0]        rx_sync_q;
   logic              rx_s;
   rx_state_e         rx_state_q, rx_state_d;
   logic [BAUD_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]        rx_bit_q, rx_bit_d;
   logic [7:0]        rx_shift_q, rx_shift_d;
   logic              rx_valid_q, rx_valid_d;

   state_e            state_q, state_d;
   logic              is_write_q, is_write_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [TMO_W-1:0]  timer_q, timer_d;
   logic [31:0]       reply_q, reply_d;
   logic [2:0]        reply_left_q, reply_left_d;
   logic [3:0]        tx_bit_q, tx_bit_d;
   logic [BAUD_W-1:0] tx_cnt_q, tx_cnt_d;
   logic              tx_level;

   logic              rreq_q, rreq_d, wreq_q, wreq_d;
   logic [31:0]       bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
   logic [3:0]        strobe_q, strobe_d;
   logic              tx_q, tx_d, busy_q, busy_d;

   assign rx_s          = rx_sync_q[1];
   assign rw_address    = bus_addr_q;
   assign write_data    = bus_wdata_q;
   assign write_strobe  = strobe_q;
   assign read_request  = rreq_q;
   assign write_request = wreq_q;
   assign uart_tx       = tx_q;
   assign bridge_busy   = busy_q;

   // Frame bit currently on the wire: start, 8 data bits LSB first, stop.
   assign tx_level = (tx_bit_q == 4'd0) ? 1'b0 :
                     (tx_bit_q > 4'd8)  ? 1'b1 :
                     reply_q[5'(5'd23 + 5'(tx_bit_q))];

   // RX deserialiser: start recheck at half bit, then one sample per bit.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + BAUD_W'(1);
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_valid_d = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (!rx_s) rx_state_d = RX_START;
         end
         RX_START: if (rx_cnt_q == BAUD_W'(CYCLES_PER_BAUD / 2)) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_s ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_cnt_q == BAUD_W'(CYCLES_PER_BAUD - 1)) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_s, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
         end
         RX_STOP: if (rx_cnt_q == BAUD_W'(CYCLES_PER_BAUD - 1)) begin
            rx_cnt_d = '0;
            if (rx_s) begin
               rx_valid_d = 1'b1;
               rx_state_d = RX_IDLE;
            end else begin
               rx_state_d = RX_WAIT;
            end
         end
         RX_WAIT: begin
            rx_cnt_d = '0;
            if (rx_s) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Command decoder, bus initiator and reply serialiser.
   always_comb begin
      state_d      = state_q;
      is_write_d   = is_write_q;
      byte_cnt_d   = byte_cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      timer_d      = timer_q;
      reply_d      = reply_q;
      reply_left_d = reply_left_q;
      tx_bit_d     = tx_bit_q;
      tx_cnt_d     = tx_cnt_q;
      rreq_d       = rreq_q;
      wreq_d       = wreq_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      strobe_d     = strobe_q;
      tx_d         = 1'b1;
      unique case (state_q)
         S_IDLE: if (rx_valid_q) begin
            byte_cnt_d = '0;
            tx_bit_d   = '0;
            tx_cnt_d   = '0;
            if (rx_shift_q == CMD_WRITE || rx_shift_q == CMD_READ) begin
               is_write_d = (rx_shift_q == CMD_WRITE);
               state_d    = S_ADDR;
            end else begin
               reply_d      = {RSP_BAD, 24'h0};
               reply_left_d = 3'd1;
               state_d      = S_REPLY;
            end
         end
         S_ADDR: if (rx_valid_q) begin
            addr_d     = {addr_q[23:0], rx_shift_q};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
               if (is_write_q) begin
                  state_d = S_DATA;
               end else begin
                  state_d    = S_BUS;
                  timer_d    = '0;
                  rreq_d     = 1'b1;
                  bus_addr_d = {addr_q[23:0], rx_shift_q};
               end
            end
         end
         S_DATA: if (rx_valid_q) begin
            wdata_d    = {wdata_q[23:0], rx_shift_q};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
               state_d     = S_BUS;
               timer_d     = '0;
               wreq_d      = 1'b1;
               bus_addr_d  = addr_q;
               bus_wdata_d = {wdata_q[23:0], rx_shift_q};
               strobe_d    = 4'hF;
            end
         end
         S_BUS: begin
            timer_d = timer_q + TMO_W'(1);
            if ((rreq_q && read_response) || (wreq_q && write_response) ||
                (timer_q == TMO_W'(BUS_TIMEOUT - 1))) begin
               rreq_d      = 1'b0;
               wreq_d      = 1'b0;
               bus_addr_d  = '0;
               bus_wdata_d = '0;
               strobe_d    = '0;
               tx_bit_d    = '0;
               tx_cnt_d    = '0;
               state_d     = S_REPLY;
               if (rreq_q && read_response) begin
                  reply_d      = read_data;
                  reply_left_d = 3'd4;
               end else if (wreq_q && write_response) begin
                  reply_d      = {RSP_ACK, 24'h0};
                  reply_left_d = 3'd1;
               end else begin
                  reply_d      = {RSP_ERR, 24'h0};
                  reply_left_d = 3'd1;
               end
            end
         end
         S_REPLY: begin
            tx_d     = tx_level;
            tx_cnt_d = tx_cnt_q + BAUD_W'(1);
            if (tx_cnt_q == BAUD_W'(CYCLES_PER_BAUD - 1)) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 4'd9) begin
                  tx_bit_d = '0;
                  if (reply_left_q > 3'd1) begin
                     reply_d      = {reply_q[23:0], 8'h00};
                     reply_left_d = reply_left_q - 3'd1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  tx_bit_d = tx_bit_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset truncates any frame and idles the line.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_sync_q    <= 2'b11;
         rx_state_q   <= RX_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_valid_q   <= 1'b0;
         state_q      <= S_IDLE;
         is_write_q   <= 1'b0;
         byte_cnt_q   <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         timer_q      <= '0;
         reply_q      <= '0;
         reply_left_q <= '0;
         tx_bit_q     <= '0;
         tx_cnt_q     <= '0;
         rreq_q       <= 1'b0;
         wreq_q       <= 1'b0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         strobe_q     <= '0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         rx_sync_q    <= {rx_sync_q[0], uart_rx};
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_valid_q   <= rx_valid_d;
         state_q      <= state_d;
         is_write_q   <= is_write_d;
         byte_cnt_q   <= byte_cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         timer_q      <= timer_d;
         reply_q      <= reply_d;
         reply_left_q <= reply_left_d;
         tx_bit_q     <= tx_bit_d;
         tx_cnt_q     <= tx_cnt_d;
         rreq_q       <= rreq_d;
         wreq_q       <= wreq_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         strobe_q     <= strobe_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
      end
   end

endmodule
